// File: rtl/pool_window_buffer.sv
// ---------------------------------------------------------------------------
// pool_window_buffer
//
// Purpose:
//   Turns a raster-order (row-major) pixel stream into non-overlapping 2x2
//   windows for a downstream max-pool stage.
//   - Even rows are written into a one-line buffer.
//   - On odd rows, the even-column pixel is held in a left register.
//   - The odd-column pixel completes a window, which is presented on n1..n4
//     one cycle after that pixel is accepted.
//   The output uses a single-entry valid/ready register. A new window may
//   replace the current one on the same edge that hands it off, so there is
//   no bubble between windows.
//
// Parameters:
//   DATA_WIDTH  pixel width in bits
//   IMG_WIDTH   feature-map columns (even, >= 2)
//   IMG_HEIGHT  feature-map rows (even, >= 2)
//
// Ports:
//   clk         single clock; all state updates on the rising edge
//   reset       asynchronous active-high reset
//   in_data     input pixel stream
//   in_valid    in_data valid
//   in_ready    block accepts in_data this cycle (!out_valid || out_ready)
//   n1..n4      window: top-left, top-right, bottom-left, bottom-right
//   out_valid   window on n1..n4 valid
//   out_ready   downstream takes the window
//   frame_done  high while the last window of a frame is presented
//
// Configuration macro:
//   POOL_RELU_EN  when defined, negative pixels (MSB set) are replaced by 0
//                 on entry. When undefined, pixels pass bit-exact.
// ---------------------------------------------------------------------------
module pool_window_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 26,
  parameter int IMG_HEIGHT = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] n1,
  output logic [DATA_WIDTH-1:0] n2,
  output logic [DATA_WIDTH-1:0] n3,
  output logic [DATA_WIDTH-1:0] n4,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done
);

  localparam int COL_W = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [DATA_WIDTH-1:0] left_q, left_d;
  logic [DATA_WIDTH-1:0] n1_q, n1_d;
  logic [DATA_WIDTH-1:0] n2_q, n2_d;
  logic [DATA_WIDTH-1:0] n3_q, n3_d;
  logic [DATA_WIDTH-1:0] n4_q, n4_d;
  logic                  out_valid_q, out_valid_d;
  logic                  frame_done_q, frame_done_d;

  // Line buffer holding the most recent even row. Its contents are not reset.
  // A stale row is never used, because the counters restart at row 0 and
  // that row overwrites every entry before the next odd row reads it.
  logic [DATA_WIDTH-1:0] line_mem [IMG_WIDTH];

  // Top-row pair for the window being assembled. It is fetched from the line
  // buffer when the odd-row, even-column pixel is accepted. The line buffer
  // is never written during an odd row, so this pair equals
  // linebuf[col-1] and linebuf[col] at the moment the window completes.
  logic [DATA_WIDTH-1:0] top_left_q;
  logic [DATA_WIDTH-1:0] top_right_q;

  // -------------------------------------------------------------------------
  // Input conditioning
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] pix;

`ifdef POOL_RELU_EN
  // Clamp negatives to zero so the unsigned downstream compare is correct.
  assign pix = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
  assign pix = in_data;
`endif

  // -------------------------------------------------------------------------
  // Handshake and position decode
  // -------------------------------------------------------------------------
  logic accept;
  logic handoff;
  logic odd_row;
  logic odd_col;
  logic last_col;
  logic last_row;
  logic load_win;
  logic write_line;
  logic fetch_top;

  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign handoff    = out_valid_q && out_ready;

  assign odd_row    = row_q[0];
  assign odd_col    = col_q[0];
  assign last_col   = (col_q == LAST_COL);
  assign last_row   = (row_q == LAST_ROW);

  assign write_line = accept && !odd_row;
  assign fetch_top  = accept &&  odd_row && !odd_col;
  assign load_win   = accept &&  odd_row &&  odd_col;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    left_d       = left_q;
    n1_d         = n1_q;
    n2_d         = n2_q;
    n3_d         = n3_q;
    n4_d         = n4_q;
    out_valid_d  = out_valid_q;
    frame_done_d = frame_done_q;

    if (accept) begin
      // Raster position: column wraps at the line end, row wraps at the
      // frame end, so the next frame can follow with no idle cycle.
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end

      if (odd_row && !odd_col) begin
        left_d = pix;
      end
    end

    // A newly completed window takes priority over the handoff clear.
    // This keeps out_valid high when a window is consumed and the next one
    // lands on the same edge.
    if (load_win) begin
      n1_d         = top_left_q;
      n2_d         = top_right_q;
      n3_d         = left_q;
      n4_d         = pix;
      out_valid_d  = 1'b1;
      frame_done_d = last_row && last_col;
    end else if (handoff) begin
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Control and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      left_q       <= '0;
      n1_q         <= '0;
      n2_q         <= '0;
      n3_q         <= '0;
      n4_q         <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      left_q       <= left_d;
      n1_q         <= n1_d;
      n2_q         <= n2_d;
      n3_q         <= n3_d;
      n4_q         <= n4_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Line buffer: one write port and registered reads
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (write_line) begin
      line_mem[col_q] <= pix;
    end
    if (fetch_top) begin
      // col_q is even here, so col_q + 1 is still inside the line.
      top_left_q  <= line_mem[col_q];
      top_right_q <= line_mem[col_q + COL_W'(1)];
    end
  end

  assign n1         = n1_q;
  assign n2         = n2_q;
  assign n3         = n3_q;
  assign n4         = n4_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule
